// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_e : sequencer states (IDLE -> CALC -> FIX -> DONE -> IDLE)
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_unit.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per clock.
// Truncating division: the quotient rounds toward zero and the remainder takes
// the dividend's sign. Dividing by zero gives an all-ones quotient and
// remainder = dividend.
//
// Ports:
//   clk_sig    : clock, rising edge
//   rst_sig    : asynchronous reset, active low
//   start      : begin a divide (sampled only in IDLE)
//   is_signed  : 1 = two's-complement, 0 = unsigned (latched with start)
//   dividend   : numerator   (latched with start)
//   divisor    : denominator (latched with start)
//   busy       : high while in CALC or FIX
//   done       : one-cycle strobe, result valid (write enable for HI/LO)
//   quotient   : result for LO, held until the next DONE
//   remainder  : result for HI, held until the next DONE
//
// Timing: start edge E0, CALC steps on E1..E(WIDTH), FIX->DONE at E(WIDTH+1),
// DONE->IDLE at E(WIDTH+2). The next start can be taken at E(WIDTH+3).
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_sig,
  input  logic             rst_sig,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] step_cnt;

  // Operands captured at the start edge.
  logic             signed_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;

  // Working registers: quo_work starts as the dividend magnitude and is
  // shifted out MSB-first while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] quo_work;
  logic [WIDTH-1:0] rem_work;

  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] trial;
  logic             fits;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  // Magnitudes. The most negative value negates to itself, which read as
  // unsigned is exactly its magnitude, so min / -1 falls out naturally.
  assign dvd_mag_in = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag    = (signed_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

  // One restoring step on a WIDTH+1-bit partial remainder. When the trial
  // subtraction succeeds its result is below the divisor, so the low WIDTH
  // bits hold it exactly.
  assign partial = {rem_work, quo_work[WIDTH-1]};
  assign fits    = (partial >= {1'b0, dvs_mag});
  assign trial   = partial[WIDTH-1:0] - dvs_mag;

  assign q_neg = signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
  assign r_neg = signed_q & dvd_q[WIDTH-1];

  // Divide-by-zero bypasses sign correction so both modes return all-ones
  // and the raw dividend.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    q_fixed = q_neg ? -quo_work : quo_work;
    r_fixed = r_neg ? -rem_work : rem_work;
    if (dvs_q == '0) begin
      q_fixed = '1;
      r_fixed = dvd_q;
    end
  end

  // State register.
  always_ff @(posedge clk_sig or negedge rst_sig) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (!rst_sig) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (step_cnt == LAST_STEP) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      // NOTE: every datapath register is reset so an aborted divide leaves no residue and outputs are never X.
      step_cnt  <= '0;
      signed_q  <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_work  <= '0;
      rem_work  <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            signed_q <= is_signed;
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            quo_work <= dvd_mag_in;
            rem_work <= '0;
            step_cnt <= '0;
          end
        end
        CALC: begin
          quo_work <= {quo_work[WIDTH-2:0], fits};
          rem_work <= fits ? trial : partial[WIDTH-1:0];
          step_cnt <= step_cnt + 1'b1;
        end
        FIX: begin
          quotient  <= q_fixed;
          remainder <= r_fixed;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule : div_unit
